uart_frame_tx: RTL
==================

# uart_frame_tx

Downstream stage of the acquisition data processor. Accepts 32-bit packed words (flag, timestamp, calibrated sample) on a one-cycle valid strobe, buffers them in a small FIFO, and serializes each word as a 6-byte framed packet on an 8N1 UART line. Input runs at up to 10 MS/s and the UART is far slower, so the block drops on overflow and reports the losses instead of back-pressuring.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk_100MHz cycles per UART bit (115200 baud); legal range ≥ 2.
- FIFO_AW, default 4: FIFO address width; depth = 2^FIFO_AW words.
- SYNC_BYTE, default 8'hA5: first byte of every frame.

Ports:
- clk_100MHz  input  1: system clock, all logic on rising edge.
- reset_n  input  1: asynchronous active-low reset.
- proc_data  input  32: packed word from the data processor.
- proc_data_valid  input  1: word strobe, one cycle per word.
- tx_enable  input  1: permits new frames to start.
- clear_status  input  1: one-cycle pulse, clears overflow and drop_count.
- uart_tx  output  1: serial line, idle high.
- tx_busy  output  1: high while a frame is on the line.
- fifo_level  output  FIFO_AW+1: words currently stored.
- overflow  output  1: sticky, set on any dropped word.
- drop_count  output  16: dropped words, saturates at 16'hFFFF.

## Operation
- FIFO write: when proc_data_valid=1 and (fifo not full OR pop in the same cycle), store proc_data.
- Drop: when proc_data_valid=1, fifo full, and no pop that cycle, discard the word, set overflow, and increment drop_count (hold at 16'hFFFF).
- clear_status: zeroes overflow and drop_count. If a drop occurs in the same cycle, the result is overflow=1 and drop_count=1.
- Frame FSM states:
  - IDLE: if tx_enable=1 and fifo not empty, pop the head word into a 32-bit holding register, compute checksum = XOR of its four bytes, set byte_idx=0, go to SEND.
  - SEND: bit engine transmits byte_idx 0..5 in this order: SYNC_BYTE, word[31:24], word[23:16], word[15:8], word[7:0], checksum. After the stop bit of byte 5, go to IDLE.
- Bit engine: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. Bytes within a frame are back-to-back with no idle gap.
- tx_enable is sampled only in IDLE. Deasserting it mid-frame has no effect until the frame completes; afterwards no new frame starts.
- fifo_level updates on every accepted write and pop. A simultaneous write and pop leaves it unchanged.
- Pointers wrap modulo 2^FIFO_AW. Full means fifo_level = 2^FIFO_AW; empty means fifo_level = 0.

## Timing
- Reset values: uart_tx=1, tx_busy=0, fifo_level=0, overflow=0, drop_count=0; FSM in IDLE; FIFO emptied.
- Assertion of reset_n low mid-frame aborts the frame immediately: uart_tx returns to 1 asynchronously and all buffered words are lost.
- Write at cycle N (with fifo empty, FSM in IDLE, tx_enable=1):
  - fifo_level=1 at N+1.
  - Pop at N+1; fifo_level=0 at N+2.
  - uart_tx=0 (start bit) and tx_busy=1 from N+2.
- Frame duration is exactly 60·CLKS_PER_BIT cycles. tx_busy deasserts the cycle after the last stop-bit cycle.
- Back-to-back frames: the FSM spends exactly one cycle in IDLE between frames, so the next start bit begins 2 cycles after the previous stop bit ends.
- overflow and drop_count update the cycle after the dropped strobe.

## Test plan
- Single word: CLKS_PER_BIT=4, word 32'h12345678, tx_enable=1 -> uart_tx decodes A5 12 34 56 78 08; start bit at strobe+2; tx_busy high for 240 cycles.
- Overflow: tx_enable=0, 20 strobes with words 0..19 -> fifo_level=16, drop_count=4, overflow=1. Then tx_enable=1 -> frames carry words 0..15 in order.
- Full with simultaneous pop: fifo full, FSM pops in the same cycle as a strobe -> word accepted, fifo_level stays 16, drop_count unchanged.
- Gating: tx_enable dropped 10 cycles into a frame -> that frame completes intact, no further frame starts, fifo_level holds.
- Status: drop_count=3, then clear_status pulsed together with a drop -> overflow=1, drop_count=1. Also drive 70000 drops -> drop_count saturates at 16'hFFFF.
- Reset mid-frame: reset_n low during byte 2 -> uart_tx=1, tx_busy=0, fifo_level=0 immediately. After release, a new word frames correctly from SYNC_BYTE.

Source files
------------

// File: rtl/uart_frame_tx.sv
// Buffers 32-bit acquisition words in a small FIFO and sends each one as a
// 6-byte 8N1 frame: sync, four data bytes MSB first, XOR checksum.
module uart_frame_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_AW      = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic [31:0]        proc_data,
  input  logic               proc_data_valid,
  input  logic               tx_enable,
  input  logic               clear_status,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]      CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LVL_FULL   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  function automatic logic [7:0] word_checksum(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [31:0] w,
                                            input logic [7:0] c);
    case (idx)
      3'd0:    return SYNC_BYTE;
      3'd1:    return w[31:24];
      3'd2:    return w[23:16];
      3'd3:    return w[15:8];
      3'd4:    return w[7:0];
      3'd5:    return c;
      default: return 8'hFF;
    endcase
  endfunction

  logic [31:0]        mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   level_r;
  logic               full_s, empty_s, pop_s, push_s, drop_s;

  state_t      state_r, state_nx;
  logic [31:0] word_r, word_nx;
  logic [7:0]  csum_r, csum_nx;
  logic [2:0]  byte_r, byte_nx;
  logic [3:0]  bit_r, bit_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic        tx_r, tx_nx;
  logic        busy_r, busy_nx;
  logic [7:0]  cur_byte_s;
  logic        overflow_r;
  logic [15:0] drop_count_r;

  assign full_s     = (level_r == LVL_FULL);
  assign empty_s    = (level_r == {(FIFO_AW + 1){1'b0}});
  // A full FIFO still accepts a word when the head is leaving the same cycle.
  assign push_s     = proc_data_valid && (!full_s || pop_s);
  assign drop_s     = proc_data_valid && full_s && !pop_s;
  assign cur_byte_s = frame_byte(byte_r, word_r, csum_r);

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk_100MHz) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= proc_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      level_r  <= {(FIFO_AW + 1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Frame FSM register and bit-engine state
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      word_r  <= 32'h0000_0000;
      csum_r  <= 8'h00;
      byte_r  <= 3'd0;
      bit_r   <= 4'd0;
      cnt_r   <= {CW{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      word_r  <= word_nx;
      csum_r  <= csum_nx;
      byte_r  <= byte_nx;
      bit_r   <= bit_nx;
      cnt_r   <= cnt_nx;
      tx_r    <= tx_nx;
      busy_r  <= busy_nx;
    end
  end

  // Next-state logic; bit_r: 0 = start, 1..8 = data LSB first, 9 = stop
  always_comb begin
    state_nx = state_r;
    word_nx  = word_r;
    csum_nx  = csum_r;
    byte_nx  = byte_r;
    bit_nx   = bit_r;
    cnt_nx   = cnt_r;
    tx_nx    = tx_r;
    busy_nx  = busy_r;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        if (tx_enable && !empty_s) begin
          pop_s    = 1'b1;
          word_nx  = mem_r[rd_ptr_r];
          csum_nx  = word_checksum(mem_r[rd_ptr_r]);
          byte_nx  = 3'd0;
          bit_nx   = 4'd0;
          cnt_nx   = {CW{1'b0}};
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = ST_SEND;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (cnt_r != CNT_MAX) begin
          cnt_nx = cnt_r + CNT_ONE;
        end else begin
          cnt_nx = {CW{1'b0}};
          if (bit_r == 4'd9) begin
            if (byte_r == 3'd5) begin
              state_nx = ST_IDLE;
              tx_nx    = 1'b1;
              busy_nx  = 1'b0;
            end else begin
              byte_nx = byte_r + 3'd1;
              bit_nx  = 4'd0;
              tx_nx   = 1'b0;
            end
          end else begin
            bit_nx = bit_r + 4'd1;
            if (bit_r == 4'd8) begin
              tx_nx = 1'b1;
            end else begin
              tx_nx = cur_byte_s[bit_r[2:0]];
            end
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Loss reporting; a drop coinciding with a clear counts as the first new drop
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'h0000;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clear_status) begin
        drop_count_r <= 16'h0001;
      end else if (drop_count_r == 16'hFFFF) begin
        drop_count_r <= 16'hFFFF;
      end else begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
    end else if (clear_status) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 16'h0000;
    end else begin
      overflow_r   <= overflow_r;
      drop_count_r <= drop_count_r;
    end
  end

  assign uart_tx    = tx_r;
  assign tx_busy    = busy_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule
